// File: rtl/axi4_w_gate_if.sv
// AXI4 W-channel bundle shared by the upstream and downstream sides of axi4_w_gate.
interface axi4_w_gate_if #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_USER_WIDTH = 2
);
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic [AXI_USER_WIDTH-1:0]   wuser;
    logic                        wvalid;
    logic                        wready;

    modport master (
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready
    );

    modport slave (
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready
    );
endinterface

// File: rtl/axi4_w_gate.sv
// AXI4 W-channel gate: forwards or discards whole W bursts according to per-burst
// decisions queued in a small FIFO. Optional feature macro RAB_W_DROP_CNT_EN adds a
// saturating 16-bit count of dropped bursts on output drop_cnt.
module axi4_w_gate #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_USER_WIDTH = 2,
    parameter int unsigned DEC_FIFO_DEPTH = 4
) (
    input  logic          axi4_aclk,
    input  logic          axi4_arstn,
    input  logic          dec_valid,
    input  logic          dec_drop,
    output logic          dec_ready,
    axi4_w_gate_if.slave  s_axi4,
    axi4_w_gate_if.master m_axi4,
    output logic          drop_done
`ifdef RAB_W_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int unsigned PtrW = $clog2(DEC_FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e                    state_q, state_d;
    logic [DEC_FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]             cnt_q, cnt_d;
    logic                      drop_done_q, drop_done_d;

    logic push, pop, empty, full, head_drop, fwd_hs, drop_hs;

    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic [AXI_USER_WIDTH-1:0]   wuser;

    // Depth is a power of two, so the count MSB alone flags a full FIFO.
    assign empty     = (cnt_q == '0);
    assign full      = cnt_q[PtrW];
    assign head_drop = mem_q[rptr_q];
    assign dec_ready = !full;
    assign push      = dec_valid && !full;
    assign fwd_hs    = (state_q == StFwd) && s_axi4.wvalid && m_axi4.wready;
    assign drop_hs   = (state_q == StDrop) && s_axi4.wvalid;
    assign drop_done = drop_done_q;

    // State, FIFO and drop pulse registers.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q     <= StIdle;
            mem_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            drop_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            drop_done_q <= drop_done_d;
        end
    end

    // Next state: load a new head from IDLE, or chain straight into it on wlast.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = head_drop ? StDrop : StFwd;
                end
            end
            StFwd, StDrop: begin
                if ((fwd_hs || drop_hs) && s_axi4.wlast) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = head_drop ? StDrop : StFwd;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Decision FIFO bookkeeping; pop only ever sees entries already registered.
    always_comb begin
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        drop_done_d = drop_hs && s_axi4.wlast;
        if (push) begin
            mem_d[wptr_q] = dec_drop;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (PtrW + 1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (PtrW + 1)'(1);
        end
    end

    // Handshake steering and zero-latency payload pass-through.
    always_comb begin
        wdata          = s_axi4.wdata;
        wstrb          = s_axi4.wstrb;
        wuser          = s_axi4.wuser;
        m_axi4.wdata   = wdata;
        m_axi4.wstrb   = wstrb;
        m_axi4.wuser   = wuser;
        m_axi4.wlast   = s_axi4.wlast;
        m_axi4.wvalid  = 1'b0;
        s_axi4.wready  = 1'b0;
        unique case (state_q)
            StFwd: begin
                m_axi4.wvalid = s_axi4.wvalid;
                s_axi4.wready = m_axi4.wready;
            end
            StDrop: begin
                s_axi4.wready = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RAB_W_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt = drop_cnt_q;

    // Saturating count of completed dropped bursts.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_done_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_w_gate.sv
// Self-checking bench for axi4_w_gate: directed scenarios plus a randomized burst
// stream scored against an in-order list of forwarded beats and dropped bursts.
module tb_axi4_w_gate;

    localparam int unsigned DW    = 32;
    localparam int unsigned UW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NB    = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic dec_valid, dec_drop, dec_ready, drop_done;
`ifdef RAB_W_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    axi4_w_gate_if #(.AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)) s_if ();
    axi4_w_gate_if #(.AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)) m_if ();

    axi4_w_gate #(
        .AXI_DATA_WIDTH(DW),
        .AXI_USER_WIDTH(UW),
        .DEC_FIFO_DEPTH(DEPTH)
    ) dut (
        .axi4_aclk (clk),
        .axi4_arstn(rst_n),
        .dec_valid (dec_valid),
        .dec_drop  (dec_drop),
        .dec_ready (dec_ready),
        .s_axi4    (s_if),
        .m_axi4    (m_if),
        .drop_done (drop_done)
`ifdef RAB_W_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;
    int unsigned cyc = 0;
    bit rnd_on;

    logic [38:0] mq_beat[$];
    int unsigned mq_cyc[$];
    int unsigned dd_cyc[$];

    // Random-phase reference: every beat in stream order, its route, and the forwarded list.
    logic [38:0] all_beat[$];
    bit          all_drop[$];
    logic [38:0] exp_fwd[$];
    bit          rb_drop[NB];
    int          exp_drops;
    int          drops_since_rst;

    logic [38:0] b[4];
    int unsigned hs[4];
    int unsigned t;
    bit mv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [38:0] s_beat();
        return {s_if.wlast, s_if.wuser, s_if.wstrb, s_if.wdata};
    endfunction

    function automatic logic [38:0] m_beat();
        return {m_if.wlast, m_if.wuser, m_if.wstrb, m_if.wdata};
    endfunction

    function automatic logic [38:0] rnd_beat(input logic last);
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        return {last, r2[1:0], r2[5:2], r1};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream monitor: record accepted beats and drop pulses, check FWD mirroring.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.wvalid) begin
                check("wready_mirror", 64'(s_if.wready), 64'(m_if.wready));
                check("payload_pass", 64'(m_beat()), 64'(s_beat()));
                if (m_if.wready) begin
                    mq_beat.push_back(m_beat());
                    mq_cyc.push_back(cyc);
                end
            end
            if (drop_done) dd_cyc.push_back(cyc);
        end
    end

    task automatic push_dec(input bit drop, output int unsigned acc_cyc);
        bit ok = 1'b0;
        dec_valid = 1'b1;
        dec_drop  = drop;
        acc_cyc   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dec_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        if (!ok) check("dec_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [38:0] bt, output int unsigned hcyc, output bit mvalid);
        bit ok = 1'b0;
        {s_if.wlast, s_if.wuser, s_if.wstrb, s_if.wdata} = bt;
        s_if.wvalid = 1'b1;
        hcyc   = 0;
        mvalid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_if.wready) begin
                ok     = 1'b1;
                hcyc   = cyc;
                mvalid = m_if.wvalid;
                break;
            end
        end
        if (!ok) check("beat_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_if.wvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        mq_beat.delete();
        mq_cyc.delete();
        dd_cyc.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int unsigned dummy;
        int n0;
        rst_n = 1'b0;
        dec_valid = 1'b0;
        dec_drop = 1'b0;
        s_if.wvalid = 1'b0;
        {s_if.wlast, s_if.wuser, s_if.wstrb, s_if.wdata} = '0;
        m_if.wready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dec_ready", 64'(dec_ready), 64'd1);
        check("rst_s_wready", 64'(s_if.wready), 64'd0);
        check("rst_m_wvalid", 64'(m_if.wvalid), 64'd0);
        check("rst_drop_done", 64'(drop_done), 64'd0);
`ifdef RAB_W_DROP_CNT_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 4-beat forward burst, W already waiting when the decision arrives.
        for (int i = 0; i < 4; i++) b[i] = rnd_beat(i == 3);
        fork
            push_dec(1'b0, t);
            for (int i = 0; i < 4; i++) send_beat(b[i], hs[i], mv);
        join
        idle(3);
        check("fwd_count", 64'(mq_beat.size()), 64'd4);
        for (int i = 0; i < 4 && i < mq_beat.size(); i++) check("fwd_beat", 64'(mq_beat[i]), 64'(b[i]));
        check("fwd_latency", 64'(mq_cyc.size() > 0 ? mq_cyc[0] : 0), 64'(t + 2));
        check("fwd_no_drop_done", 64'(dd_cyc.size()), 64'd0);
        clear_q();

        // 3-beat drop burst.
        push_dec(1'b1, t);
        for (int i = 0; i < 3; i++) send_beat(rnd_beat(i == 2), hs[i], mv);
        idle(3);
        check("drop_contig1", 64'(hs[1]), 64'(hs[0] + 1));
        check("drop_contig2", 64'(hs[2]), 64'(hs[1] + 1));
        check("drop_no_fwd", 64'(mq_beat.size()), 64'd0);
        check("drop_done_count", 64'(dd_cyc.size()), 64'd1);
        check("drop_done_cycle", 64'(dd_cyc.size() > 0 ? dd_cyc[0] : 0), 64'(hs[2] + 1));
        clear_q();

        // F, D, F single-beat bursts with a continuous W stream.
        push_dec(1'b0, dummy);
        push_dec(1'b1, dummy);
        push_dec(1'b0, dummy);
        for (int i = 0; i < 3; i++) b[i] = rnd_beat(1'b1);
        for (int i = 0; i < 3; i++) send_beat(b[i], hs[i], mv);
        idle(3);
        check("fdf_nobubble1", 64'(hs[1]), 64'(hs[0] + 1));
        check("fdf_nobubble2", 64'(hs[2]), 64'(hs[1] + 1));
        check("fdf_count", 64'(mq_beat.size()), 64'd2);
        check("fdf_beat1", 64'(mq_beat.size() > 0 ? mq_beat[0] : 0), 64'(b[0]));
        check("fdf_beat3", 64'(mq_beat.size() > 1 ? mq_beat[1] : 0), 64'(b[2]));
        check("fdf_drop_done", 64'(dd_cyc.size() > 0 ? dd_cyc[0] : 0), 64'(hs[1] + 1));
        clear_q();

        // Fill the FIFO with W stalled: depth plus the one entry moved into the FSM.
        acc = 0;
        dec_valid = 1'b1;
        dec_drop = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dec_ready) acc++;
            @(posedge clk);
            #1;
        end
        dec_valid = 1'b0;
        check("fifo_accept", 64'(acc), 64'(DEPTH + 1));
        @(negedge clk);
        check("fifo_full_ready", 64'(dec_ready), 64'd0);
        @(posedge clk);
        #1;
        send_beat(rnd_beat(1'b1), hs[0], mv);
        @(negedge clk);
        check("ready_after_pop", 64'(dec_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) send_beat(rnd_beat(1'b1), hs[0], mv);
        idle(3);
        check("fifo_drain", 64'(mq_beat.size()), 64'(DEPTH + 1));
        clear_q();

        // Forward with downstream ready toggling.
        push_dec(1'b0, dummy);
        for (int i = 0; i < 4; i++) b[i] = rnd_beat(i == 3);
        fork
            for (int i = 0; i < 20; i++) begin
                m_if.wready = (i % 2 == 0);
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 4; i++) send_beat(b[i], hs[i], mv);
        join
        m_if.wready = 1'b1;
        idle(2);
        check("toggle_count", 64'(mq_beat.size()), 64'd4);
        for (int i = 0; i < 4 && i < mq_beat.size(); i++) check("toggle_beat", 64'(mq_beat[i]), 64'(b[i]));
        clear_q();

        // Reset in the middle of a forward burst.
        push_dec(1'b0, dummy);
        for (int i = 0; i < 2; i++) send_beat(rnd_beat(1'b0), hs[i], mv);
        {s_if.wlast, s_if.wuser, s_if.wstrb, s_if.wdata} = rnd_beat(1'b0);
        s_if.wvalid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_s_wready", 64'(s_if.wready), 64'd0);
        check("mid_rst_m_wvalid", 64'(m_if.wvalid), 64'd0);
        check("mid_rst_dec_ready", 64'(dec_ready), 64'd1);
        check("mid_rst_drop_done", 64'(drop_done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = mq_beat.size();
        repeat (5) begin
            @(negedge clk);
            check("post_rst_s_wready", 64'(s_if.wready), 64'd0);
            @(posedge clk);
            #1;
        end
        s_if.wvalid = 1'b0;
        check("post_rst_no_fwd", 64'(mq_beat.size()), 64'(n0));
        clear_q();
        push_dec(1'b0, dummy);
        b[0] = rnd_beat(1'b1);
        send_beat(b[0], hs[0], mv);
        idle(2);
        check("post_rst_fwd", 64'(mq_beat.size() > 0 ? mq_beat[0] : 0), 64'(b[0]));
        for (int i = 0; i < 2; i++) begin
            push_dec(1'b1, dummy);
            send_beat(rnd_beat(1'b1), hs[0], mv);
        end
        idle(3);
        drops_since_rst = 2;
        check("post_rst_drops", 64'(dd_cyc.size()), 64'd2);
`ifdef RAB_W_DROP_CNT_EN
        check("drop_cnt_2", 64'(drop_cnt), 64'd2);
`endif
        clear_q();

        // Randomized burst stream with random gaps and downstream backpressure.
        exp_drops = 0;
        for (int i = 0; i < NB; i++) begin
            int len;
            len = $urandom_range(1, 4);
            rb_drop[i] = ($urandom_range(0, 2) == 0);
            if (rb_drop[i]) exp_drops++;
            for (int k = 0; k < len; k++) begin
                logic [38:0] bt;
                bt = rnd_beat(k == len - 1);
                all_beat.push_back(bt);
                all_drop.push_back(rb_drop[i]);
                if (!rb_drop[i]) exp_fwd.push_back(bt);
            end
        end
        rnd_on = 1'b1;
        fork
            begin
                fork
                    for (int i = 0; i < NB; i++) begin
                        int unsigned tc;
                        idle($urandom_range(0, 2));
                        push_dec(rb_drop[i], tc);
                    end
                    for (int j = 0; j < all_beat.size(); j++) begin
                        int unsigned hc;
                        bit mvo;
                        idle($urandom_range(0, 1));
                        send_beat(all_beat[j], hc, mvo);
                        check("beat_route", 64'(mvo), 64'(!all_drop[j]));
                    end
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    m_if.wready = $urandom_range(0, 1);
                    @(posedge clk);
                    #1;
                end
                m_if.wready = 1'b1;
            end
        join
        idle(3);
        check("rnd_fwd_count", 64'(mq_beat.size()), 64'(exp_fwd.size()));
        for (int i = 0; i < exp_fwd.size() && i < mq_beat.size(); i++)
            check("rnd_fwd_beat", 64'(mq_beat[i]), 64'(exp_fwd[i]));
        check("rnd_drop_count", 64'(dd_cyc.size()), 64'(exp_drops));
`ifdef RAB_W_DROP_CNT_EN
        check("rnd_drop_cnt", 64'(drop_cnt), 64'(drops_since_rst + exp_drops));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
